pad_ctrl: RTL

SHA-512 message padding sequencer for the IPU data path. It drives the `pktmux` select lines (`pad_pkt`, `zero_pkt`, `mgln_pkt`) and `msg_len` word by word. Incoming 64-bit message words pass through unchanged, followed by the padding word, the zero words and the length word. The output is a stream of 16-word blocks for the message schedule.

---
 rtl/pad_ctrl_pkg.sv | 15 +
 rtl/pad_ctrl_if.sv | 28 ++
 rtl/len_cnt.sv | 20 ++
 rtl/pad_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/pad_ctrl_pkg.sv
// Shared SHA-2 padding constants and FSM state encodings.
package pad_ctrl_pkg;
  localparam int W   = 64;
  localparam int WPB = 16;
  localparam int IW  = $clog2(WPB);
  localparam int BPW = 64;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAD,
    ZERO,
    LEN
  } state_t;
endpackage

// File: rtl/pad_ctrl_if.sv
// Word stream and pktmux select bundle between the padder and its peers.
interface pad_ctrl_if;
  logic                        in_vld;
  logic                        in_last;
  logic                        in_rdy;
  logic                        out_rdy;
  logic                        o_vld;
  logic                        pad_pkt;
  logic                        zero_pkt;
  logic                        mgln_pkt;
  logic [pad_ctrl_pkg::W-1:0]  msg_len;
  logic [pad_ctrl_pkg::IW-1:0] word_idx;
  logic                        blk_last;

  modport master (
    input  in_vld, in_last, out_rdy,
    output in_rdy, o_vld,
    output pad_pkt, zero_pkt, mgln_pkt,
    output msg_len, word_idx, blk_last
  );

  modport slave (
    output in_vld, in_last, out_rdy,
    input  in_rdy, o_vld,
    input  pad_pkt, zero_pkt, mgln_pkt,
    input  msg_len, word_idx, blk_last
  );
endinterface

// File: rtl/len_cnt.sv
// Message length accumulator: clear, or add one word's worth of bits.
module len_cnt #(
  parameter int W    = 64,
  parameter int STEP = 64
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] len
);
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      len <= '0;
    else if (clr)
      len <= '0;
    else if (inc)
      len <= len + W'(STEP);
  end
endmodule

// File: rtl/pad_ctrl.sv
// SHA-512 padding sequencer: data pass-through, PAD, ZERO fill, LEN.
module pad_ctrl
  import pad_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_b,
  input  logic      start,
  input  logic      empty,
  output logic      busy,
  output logic      done,
  pad_ctrl_if.master bus
);
  localparam logic [IW-1:0] ZLAST = IW'(WPB - 2);
  localparam logic [IW-1:0] BLAST = IW'(WPB - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic          pad_q;
  logic          zero_q;
  logic          mgln_q;
  logic          in_data;
  logic          xfer;

  assign in_data      = (state == DATA);
  assign bus.o_vld    = in_data ? bus.in_vld
                                : (pad_q | zero_q | mgln_q);
  assign bus.in_rdy   = in_data & bus.out_rdy;
  assign xfer         = bus.o_vld & bus.out_rdy;
  assign bus.pad_pkt  = pad_q;
  assign bus.zero_pkt = zero_q;
  assign bus.mgln_pkt = mgln_q;
  assign bus.word_idx = idx;
  assign bus.blk_last = (idx == BLAST);

  len_cnt #(.W(W), .STEP(BPW)) u_len (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   ((state == IDLE) & start),
    .inc   (in_data & xfer),
    .len   (bus.msg_len)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state  <= IDLE;
      idx    <= '0;
      pad_q  <= 1'b0;
      zero_q <= 1'b0;
      mgln_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          idx  <= '0;
          busy <= 1'b1;
          if (empty) begin
            state <= PAD;
            pad_q <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (xfer) begin
          idx <= idx + 1'b1;
          if (bus.in_last) begin
            state <= PAD;
            pad_q <= 1'b1;
          end
        end
        // Length field spans words WPB-2..WPB-1, so ZERO always follows PAD.
        PAD: if (xfer) begin
          idx    <= idx + 1'b1;
          state  <= ZERO;
          pad_q  <= 1'b0;
          zero_q <= 1'b1;
        end
        ZERO: if (xfer) begin
          idx <= idx + 1'b1;
          if (idx == ZLAST) begin
            state  <= LEN;
            zero_q <= 1'b0;
            mgln_q <= 1'b1;
          end
        end
        LEN: if (xfer) begin
          idx    <= idx + 1'b1;
          state  <= IDLE;
          mgln_q <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
